// File: rtl/adc_ctrl_pkg.sv
// Shared types for the ADC32 sharing controller: state encoding, captured-op record, word helpers.
// Pure declarations; no timing or flow control of its own.
package adc_ctrl_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_RSP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      LO   = ST_LO,
      HI   = ST_HI,
      RSP  = ST_RSP
   } state_t;

   // Only the upper words need to survive past the grant cycle.
   typedef struct packed {
      logic [WORD_W-1:0] a_hi;
      logic [WORD_W-1:0] b_hi;
      logic              sub;
      logic              wide;
   } op_t;

   function automatic logic [WORD_W-1:0] opnd_b(input logic [WORD_W-1:0] b, input logic sub);
      return sub ? ~b : b;
   endfunction

   function automatic logic ovf_word(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/adc32_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; one-hot grant, index and next pointer.
// Purely combinational; the caller decides when a grant is honoured.
module rr_arbiter
#(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any,
   output logic [IDW-1:0]  next_ptr
);

   int cand;

   always_comb begin
      gnt      = '0;
      idx      = '0;
      any      = 1'b0;
      next_ptr = ptr;
      cand     = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IDW'(cand);
            next_ptr  = (cand == NREQ - 1) ? '0 : IDW'(cand + 1);
         end
      end
   end

endmodule

// File: rtl/adc32_share_ctrl.sv
// Shares one external 32-bit adder among NREQ requesters; 64-bit ops take two adder cycles, carry chained.
// Response valid 2 (narrow) / 3 (wide) cycles after grant, held until rsp_ready; no grants while busy.
module adc32_share_ctrl
   import adc_ctrl_pkg::*;
#(
   parameter int  NREQ = 2,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*64-1:0]  req_a,
   input  logic [NREQ*64-1:0]  req_b,
   input  logic [NREQ-1:0]     req_sub,
   input  logic [NREQ-1:0]     req_wide,
   output logic [WORD_W-1:0]   add_a,
   output logic [WORD_W-1:0]   add_b,
   output logic                add_c0,
   input  logic [WORD_W-1:0]   add_s,
   input  logic                add_co,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [63:0]         rsp_sum,
   output logic                rsp_co,
   output logic                rsp_ovf
);

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   op_t             op;

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
   logic [IDW-1:0]  rr_next;

   logic [63:0]     a_g;
   logic [63:0]     b_g;
   logic            sub_g;
   logic            wide_g;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .gnt      (gnt),
      .idx      (gnt_idx),
      .any      (gnt_any),
      .next_ptr (rr_next)
   );

   assign req_ready = (state == IDLE) ? gnt : '0;

   always_comb begin
      a_g    = '0;
      b_g    = '0;
      sub_g  = 1'b0;
      wide_g = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            a_g    = req_a[64*i +: 64];
            b_g    = req_b[64*i +: 64];
            sub_g  = req_sub[i];
            wide_g = req_wide[i];
         end
      end
   end

   // Adder operands are registered a cycle ahead, so add_* already carry the
   // right word during LO/HI and return to zero in IDLE/RSP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op        <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_c0    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_co    <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  op.a_hi <= a_g[63:32];
                  op.b_hi <= b_g[63:32];
                  op.sub  <= sub_g;
                  op.wide <= wide_g;
                  rsp_id  <= gnt_idx;
                  rsp_sum <= '0;
                  add_a   <= a_g[31:0];
                  add_b   <= opnd_b(b_g[31:0], sub_g);
                  add_c0  <= sub_g;
                  rr_ptr  <= rr_next;
                  state   <= LO;
               end
            end
            LO: begin
               rsp_sum[31:0] <= add_s;
               rsp_co        <= add_co;
               rsp_ovf       <= ovf_word(add_a[WORD_W-1], add_b[WORD_W-1], add_s[WORD_W-1]);
               if (op.wide) begin
                  add_a  <= op.a_hi;
                  add_b  <= opnd_b(op.b_hi, op.sub);
                  add_c0 <= add_co;
                  state  <= HI;
               end else begin
                  add_a     <= '0;
                  add_b     <= '0;
                  add_c0    <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
               end
            end
            HI: begin
               rsp_sum[63:32] <= add_s;
               rsp_co         <= add_co;
               rsp_ovf        <= ovf_word(add_a[WORD_W-1], add_b[WORD_W-1], add_s[WORD_W-1]);
               add_a          <= '0;
               add_b          <= '0;
               add_c0         <= 1'b0;
               rsp_valid      <= 1'b1;
               state          <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc32_share_ctrl.sv
// Self-checking bench for adc32_share_ctrl with a behavioural adder and a plain-arithmetic result model.
// Randomised operands and requesters; checks grants, latency, results, backpressure and mid-op reset.
module tb_adc32_share_ctrl;

   localparam int NREQ = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [127:0]  req_a;
   logic [127:0]  req_b;
   logic [1:0]    req_sub;
   logic [1:0]    req_wide;
   logic [31:0]   add_a;
   logic [31:0]   add_b;
   logic          add_c0;
   logic [31:0]   add_s;
   logic          add_co;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [0:0]    rsp_id;
   logic [63:0]   rsp_sum;
   logic          rsp_co;
   logic          rsp_ovf;

   logic [63:0]   a_l [2];
   logic [63:0]   b_l [2];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rr_model = 0;

   assign req_a = {a_l[1], a_l[0]};
   assign req_b = {b_l[1], b_l[0]};
   assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'h0, add_c0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adc32_share_ctrl #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .req_wide  (req_wide),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_c0    (add_c0),
      .add_s     (add_s),
      .add_co    (add_co),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_co    (rsp_co),
      .rsp_ovf   (rsp_ovf)
   );

   // Reference: result as true two's-complement arithmetic on the whole operand width.
   function automatic void ref_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                  input logic wide, output logic [63:0] s, output logic co,
                                  output logic ovf, output logic c_lo);
      logic signed [64:0] rw;
      logic signed [32:0] rn;
      logic [64:0]        uw;
      logic [32:0]        un;
      logic [31:0]        lo;
      un   = {1'b0, a[31:0]} + {1'b0, b[31:0]};
      c_lo = sub ? (a[31:0] >= b[31:0]) : un[32];
      if (wide) begin
         uw  = {1'b0, a} + {1'b0, b};
         rw  = sub ? ($signed({a[63], a}) - $signed({b[63], b}))
                   : ($signed({a[63], a}) + $signed({b[63], b}));
         s   = sub ? (a - b) : (a + b);
         co  = sub ? (a >= b) : uw[64];
         ovf = rw[64] ^ rw[63];
      end else begin
         rn  = sub ? ($signed({a[31], a[31:0]}) - $signed({b[31], b[31:0]}))
                   : ($signed({a[31], a[31:0]}) + $signed({b[31], b[31:0]}));
         lo  = sub ? (a[31:0] - b[31:0]) : (a[31:0] + b[31:0]);
         s   = {32'h0, lo};
         co  = c_lo;
         ovf = rn[32] ^ rn[31];
      end
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic wide, input string tag);
      logic [63:0] es;
      logic        eco, eovf, eclo;
      int          acc, t;
      bit          got;
      ref_op(a, b, sub, wide, es, eco, eovf, eclo);
      @(negedge clk);
      a_l[id] = a; b_l[id] = b; req_sub[id] = sub; req_wide[id] = wide;
      req_valid[id] = 1'b1;
      rsp_ready = 1'b1;
      #1;
      t = 0;
      while (req_ready == 2'b00 && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (req_ready !== (2'b01 << id)) begin
         errors++;
         $display("FAIL %s grant: got %b want %b", tag, req_ready, 2'b01 << id);
         req_valid[id] = 1'b0;
         return;
      end
      rr_model = (id + 1) % NREQ;
      acc = cyc;
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
      got = 0;
      t = 0;
      while (t < 10) begin
         @(negedge clk);
         if (wide && cyc == acc + 2) begin
            checks++;
            if (add_c0 !== eclo) begin
               errors++;
               $display("FAIL %s hi_c0: got %b want %b", tag, add_c0, eclo);
            end
         end
         if (rsp_valid) begin
            got = 1;
            break;
         end
         t++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s rsp_timeout: got no rsp_valid want rsp_valid", tag);
         return;
      end
      checks++;
      if ((cyc - acc) !== (wide ? 3 : 2)) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", tag, cyc - acc, wide ? 3 : 2);
      end
      checks++;
      if (rsp_id !== 1'(id)) begin
         errors++;
         $display("FAIL %s id: got %0d want %0d", tag, rsp_id, id);
      end
      checks++;
      if (rsp_sum !== es) begin
         errors++;
         $display("FAIL %s sum: got %h want %h", tag, rsp_sum, es);
      end
      checks++;
      if ({rsp_co, rsp_ovf} !== {eco, eovf}) begin
         errors++;
         $display("FAIL %s co_ovf: got %b%b want %b%b", tag, rsp_co, rsp_ovf, eco, eovf);
      end
      checks++;
      if ({add_a, add_b, add_c0} !== 65'h0) begin
         errors++;
         $display("FAIL %s adder_idle: got %h %h %b want zeros", tag, add_a, add_b, add_c0);
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready: got %b want 00", req_ready); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
      checks++;
      if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset rsp_id: got %b want 0", rsp_id); end
      checks++;
      if (rsp_sum !== 64'h0) begin errors++; $display("FAIL reset rsp_sum: got %h want 0", rsp_sum); end
      checks++;
      if ({rsp_co, rsp_ovf} !== 2'b00) begin errors++; $display("FAIL reset co_ovf: got %b%b want 00", rsp_co, rsp_ovf); end
      checks++;
      if ({add_a, add_b, add_c0} !== 65'h0) begin errors++; $display("FAIL reset adder: got %h %h %b want zeros", add_a, add_b, add_c0); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid} !== 3'b000) begin errors++; $display("FAIL idle_quiet: got %b %b want 00 0", req_ready, rsp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] es;
      logic        eco, eovf, eclo;
      int          acc_n, rsp_n, t, exp_g, pend_id;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         a_l[i] = {rnd_word(), rnd_word()}; b_l[i] = {rnd_word(), rnd_word()};
         req_sub[i] = 1'($urandom_range(0, 1)); req_wide[i] = 1'($urandom_range(0, 1));
      end
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      #1;
      exp_g = rr_model; acc_n = 0; rsp_n = 0; t = 0; pend_id = 0;
      es = '0; eco = 0; eovf = 0;
      while ((acc_n < 4 || rsp_n < acc_n) && t < 100) begin
         if (rsp_valid) begin
            checks++;
            if ({rsp_id, rsp_sum, rsp_co, rsp_ovf} !== {1'(pend_id), es, eco, eovf}) begin
               errors++;
               $display("FAIL b2b rsp%0d: got id%0d %h %b%b want id%0d %h %b%b", rsp_n,
                        rsp_id, rsp_sum, rsp_co, rsp_ovf, pend_id, es, eco, eovf);
            end
            rsp_n++;
         end
         if (req_ready != 2'b00) begin
            checks++;
            if (req_ready !== (2'b01 << exp_g)) begin
               errors++;
               $display("FAIL b2b grant%0d: got %b want %b", acc_n, req_ready, 2'b01 << exp_g);
            end
            pend_id = exp_g;
            ref_op(a_l[pend_id], b_l[pend_id], req_sub[pend_id], req_wide[pend_id], es, eco, eovf, eclo);
            rr_model = (exp_g + 1) % NREQ;
            acc_n++;
            @(posedge clk);
            #1;
            if (acc_n == 4) req_valid = 2'b00;
            else begin
               a_l[pend_id] = {rnd_word(), rnd_word()}; b_l[pend_id] = {rnd_word(), rnd_word()};
               req_sub[pend_id] = 1'($urandom_range(0, 1)); req_wide[pend_id] = 1'($urandom_range(0, 1));
            end
            exp_g = rr_model;
         end
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 100) begin
         errors++;
         $display("FAIL b2b timeout: got %0d accepts %0d rsps want 4 4", acc_n, rsp_n);
      end
      req_valid = 2'b00;
      @(posedge clk);
   endtask

   task automatic test_directed();
      run_op(0, 64'd100, 64'd123, 1'b0, 1'b0, "add_100_123");
      run_op(0, 64'h7FFF_FFFF, 64'd3, 1'b0, 1'b0, "add_ovf");
      run_op(0, 64'd5, 64'd7, 1'b1, 1'b0, "sub_5_7");
      run_op(1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, "wide_carry");
      run_op(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, "wide_sub_ovf");
      run_op(0, 64'hDEAD_BEEF_0000_0001, 64'd2, 1'b1, 1'b0, "narrow_ignores_hi");
   endtask

   task automatic test_backpressure();
      logic [63:0] es;
      logic        eco, eovf, eclo;
      int          t;
      @(negedge clk);
      a_l[0] = {rnd_word(), rnd_word()}; b_l[0] = {rnd_word(), rnd_word()};
      req_sub[0] = 1'($urandom_range(0, 1)); req_wide[0] = 1'b0;
      ref_op(a_l[0], b_l[0], req_sub[0], 1'b0, es, eco, eovf, eclo);
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      #1;
      t = 0;
      while (req_ready == 2'b00 && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL bp grant0: got %b want 01", req_ready); end
      rr_model = 1;
      @(posedge clk);
      #1 req_valid = 2'b10;
      t = 0;
      while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf, req_ready} !== {1'b1, 1'b0, es, eco, eovf, 2'b00}) begin
            errors++;
            $display("FAIL bp hold%0d: got v%b id%0d %h %b%b rdy%b want v1 id0 %h %b%b rdy00", i,
                     rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf, req_ready, es, eco, eovf);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid} !== 3'b10_0) begin
         errors++;
         $display("FAIL bp next_grant: got %b %b want 10 0", req_ready, rsp_valid);
      end
      req_valid = 2'b00;
      #1;
      req_valid = 2'b00;
      @(posedge clk);
      rr_model = 1;
      run_op(1, {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, 1'b1, 1'b1, "bp_followup");
   endtask

   task automatic test_reset_mid();
      int t;
      bit seen;
      @(negedge clk);
      a_l[1] = 64'h0000_0001_FFFF_FFFF; b_l[1] = 64'h0000_0002_0000_0001;
      req_sub[1] = 1'b0; req_wide[1] = 1'b1;
      req_valid = 2'b10;
      rsp_ready = 1'b1;
      #1;
      t = 0;
      while (req_ready == 2'b00 && t < 20) begin @(negedge clk); t++; end
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf} !== 70'h0) begin
         errors++;
         $display("FAIL midrst rsp: got rdy%b v%b id%0d %h %b%b want zeros", req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf);
      end
      checks++;
      if ({add_a, add_b, add_c0} !== 65'h0) begin
         errors++;
         $display("FAIL midrst adder: got %h %h %b want zeros", add_a, add_b, add_c0);
      end
      rr_model = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL midrst stale_rsp: got rsp_valid want none"); end
      run_op(1, 64'h0000_0001_FFFF_FFFF, 64'h0000_0002_0000_0001, 1'b0, 1'b1, "after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_op($urandom_range(0, 1), {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b00;
      req_sub = 2'b00;
      req_wide = 2'b00;
      rsp_ready = 1'b0;
      a_l[0] = '0; a_l[1] = '0;
      b_l[0] = '0; b_l[1] = '0;
      test_reset();
      test_back_to_back();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
